// File: rtl/rmii_tx_serializer.sv
// RMII transmit serializer: preamble/SFD, frame_len payload bytes from the upstream queue,
// then the inter-frame gap. Two bits per 50 MHz reference clock, all outputs registered.
module rmii_tx_serializer #(
   parameter int unsigned LEN_WIDTH      = 11,
   parameter int unsigned PREAMBLE_BYTES = 7,
   parameter int unsigned IFG_BYTES      = 12
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 start,
   input  logic [LEN_WIDTH-1:0] frame_len,
   input  logic [7:0]           byte_in,
   output logic                 advance,
   output logic [1:0]           txd,
   output logic                 txen,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned PRE_CYC = PREAMBLE_BYTES * 4;
   localparam int unsigned IFG_CYC = IFG_BYTES * 4;
   localparam int unsigned MAX_CYC = (PRE_CYC > IFG_CYC) ? PRE_CYC : IFG_CYC;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_CYC - 1);
   localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_CYC - 1);
   localparam logic [CNT_W-1:0] DIBIT_2  = CNT_W'(2);
   localparam logic [CNT_W-1:0] DIBIT_3  = CNT_W'(3);

   typedef enum logic [2:0] {StIdle, StPreamble, StSfd, StData, StIfg} state_t;

   state_t               r_state, w_state;
   logic [CNT_W-1:0]     r_cnt, w_cnt;
   logic [LEN_WIDTH-1:0] r_bytes, w_bytes;
   logic [7:0]           r_shift, w_shift;
   logic [1:0]           r_txd, w_txd;
   logic                 r_txen, w_txen;
   logic                 r_advance, w_advance;
   logic                 r_done, w_done;
   logic                 r_busy, w_busy;
   logic                 w_load;

   // Registers hold what is on the wire in the current cycle; r_cnt indexes that cycle
   // within its phase, so every output below is the value for the cycle after this edge.
   always_comb begin
      w_state   = r_state;
      w_cnt     = r_cnt + 1'b1;
      w_bytes   = r_bytes;
      w_shift   = r_shift;
      w_txd     = 2'b00;
      w_txen    = 1'b0;
      w_advance = 1'b0;
      w_done    = 1'b0;
      w_load    = 1'b0;
      unique case (r_state)
         StIdle: begin
            w_cnt = '0;
            if (start && (frame_len != '0)) begin
               w_state = StPreamble;
               w_bytes = frame_len;
               w_txen  = 1'b1;
               w_txd   = 2'b01;
            end
         end
         StPreamble: begin
            w_txen = 1'b1;
            w_txd  = 2'b01;
            if (r_cnt == PRE_LAST) begin
               w_state = StSfd;
               w_cnt   = '0;
            end
         end
         StSfd: begin
            w_txen = 1'b1;
            w_txd  = (r_cnt == DIBIT_2) ? 2'b11 : 2'b01;
            if (r_cnt == DIBIT_3) begin
               w_state = StData;
               w_load  = 1'b1;
            end
         end
         StData: begin
            w_txen  = 1'b1;
            w_txd   = r_shift[3:2];
            w_shift = r_shift >> 2;
            if (r_cnt == DIBIT_3) begin
               if (r_bytes == '0) begin
                  w_state = StIfg;
                  w_cnt   = '0;
                  w_txen  = 1'b0;
                  w_txd   = 2'b00;
                  w_done  = 1'b1;
               end else begin
                  w_load = 1'b1;
               end
            end
         end
         StIfg: begin
            if (r_cnt == IFG_LAST) begin
               w_state = StIdle;
               w_cnt   = '0;
            end
         end
         default: w_state = StIdle;
      endcase
      // Head byte is sampled on the edge that starts its first dibit; r_bytes counts what remains.
      if (w_load) begin
         w_cnt     = '0;
         w_shift   = byte_in;
         w_txd     = byte_in[1:0];
         w_advance = 1'b1;
         w_bytes   = r_bytes - 1'b1;
      end
      w_busy = (w_state != StIdle);
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state   <= StIdle;
         r_cnt     <= '0;
         r_bytes   <= '0;
         r_shift   <= '0;
         r_txd     <= 2'b00;
         r_txen    <= 1'b0;
         r_advance <= 1'b0;
         r_done    <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_cnt     <= w_cnt;
         r_bytes   <= w_bytes;
         r_shift   <= w_shift;
         r_txd     <= w_txd;
         r_txen    <= w_txen;
         r_advance <= w_advance;
         r_done    <= w_done;
         r_busy    <= w_busy;
      end
   end

   assign txd     = r_txd;
   assign txen    = r_txen;
   assign advance = r_advance;
   assign done    = r_done;
   assign busy    = r_busy;

endmodule

// File: tb/tb_rmii_tx_serializer.sv
// Bench for rmii_tx_serializer: directed and random frames against a per-cycle frame model,
// with a byte queue standing in for the upstream queue_fifo.
module tb_rmii_tx_serializer;

   localparam int PRE_B   = 7;
   localparam int IFG_B   = 12;
   localparam int HDR     = (PRE_B + 1) * 4;  // preamble + SFD cycles
   localparam int IFG_CYC = IFG_B * 4;

   logic        clk_in    = 1'b0;
   logic        rst_in    = 1'b0;
   logic        start     = 1'b0;
   logic [10:0] frame_len = '0;
   logic [7:0]  byte_in   = '0;
   logic        advance;
   logic [1:0]  txd;
   logic        txen;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   logic [7:0] q[$];
   logic [7:0] fdata[64];

   always #10 clk_in = ~clk_in;

   rmii_tx_serializer #(
      .LEN_WIDTH     (11),
      .PREAMBLE_BYTES(PRE_B),
      .IFG_BYTES     (IFG_B)
   ) dut (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .start    (start),
      .frame_len(frame_len),
      .byte_in  (byte_in),
      .advance  (advance),
      .txd      (txd),
      .txen     (txen),
      .busy     (busy),
      .done     (done)
   );

   // Expected {txen, txd, advance, done, busy} for cycle k (1 = cycle after the accepting edge).
   function automatic logic [5:0] expect_vec(input int k, input int len);
      int d_end;
      int g_end;
      int j;
      int m;
      logic [7:0] b;
      d_end = HDR + 4 * len;
      g_end = d_end + IFG_CYC;
      if (k < HDR) return 6'b1_01_0_0_1;
      if (k == HDR) return 6'b1_11_0_0_1;
      if (k <= d_end) begin
         j = (k - HDR - 1) / 4;
         m = (k - HDR - 1) % 4;
         b = fdata[j] >> (2 * m);
         return {1'b1, b[1:0], m == 0, 1'b0, 1'b1};
      end
      if (k <= g_end) return {3'b000, 1'b0, k == d_end + 1, 1'b1};
      return 6'b0;
   endfunction

   task automatic check(input string tag, input int k, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s at %0d: observed %0h expected %0h", tag, k, obs, exp);
      end
   endtask

   // Sample mid-cycle; the queue model pops on each observed advance.
   task automatic tick(output logic [5:0] obs);
      @(negedge clk_in);
      obs = {txen, txd, advance, done, busy};
      if (advance && q.size() > 0) void'(q.pop_front());
      byte_in = (q.size() > 0) ? q[0] : 8'h00;
   endtask

   task automatic idle_ticks(input int n, input string tag);
      logic [5:0] obs;
      for (int i = 0; i < n; i++) begin
         tick(obs);
         check(tag, i, {26'd0, obs}, 32'd0);
      end
   endtask

   task automatic load_frame(input int len);
      for (int i = 0; i < len; i++) begin
         fdata[i] = 8'($urandom);
         q.push_back(fdata[i]);
      end
      byte_in = q[0];
   endtask

   task automatic run_frame(input int len, input bit hold, input int pa, input int pb,
                            input string tag);
      logic [5:0] obs;
      int n_en;
      int n_adv;
      int g_end;
      n_en  = 0;
      n_adv = 0;
      g_end = HDR + 4 * len + IFG_CYC;
      start     = 1'b1;
      frame_len = 11'(len);
      @(posedge clk_in);
      #1;
      if (!hold) start = 1'b0;
      for (int k = 1; k <= g_end + 1; k++) begin
         tick(obs);
         check(tag, k, {26'd0, obs}, {26'd0, expect_vec(k, len)});
         n_en  += int'(obs[5]);
         n_adv += int'(obs[2]);
         if (k == pa || k == pb) begin
            start     = 1'b1;
            frame_len = 11'd1;
         end else if (!hold) begin
            start = 1'b0;
         end
      end
      check({tag, "_txen_total"}, len, n_en, HDR + 4 * len);
      check({tag, "_adv_total"}, len, n_adv, len);
   endtask

   initial begin
      logic [5:0] obs;
      int len;

      // Reset held, then released.
      repeat (3) begin
         tick(obs);
         check("reset_outputs", 0, {26'd0, obs}, 32'd0);
      end
      rst_in = 1'b1;
      idle_ticks(3, "post_reset_idle");

      // Single byte 0xA5, then a frame with ignored start pulses accepted in the first IDLE cycle.
      fdata[0] = 8'hA5;
      q.push_back(8'hA5);
      byte_in = q[0];
      run_frame(1, 1'b0, 0, 0, "one_byte");
      load_frame(1);
      run_frame(1, 1'b0, 10, 60, "ignored_pulses");
      idle_ticks(3, "after_pulses_idle");

      // Three-byte frame drawn from a four-entry queue.
      fdata[0] = 8'h01;
      fdata[1] = 8'h02;
      fdata[2] = 8'h03;
      q.delete();
      q.push_back(8'h01);
      q.push_back(8'h02);
      q.push_back(8'h03);
      q.push_back(8'h44);
      byte_in = q[0];
      run_frame(3, 1'b0, 0, 0, "three_byte");
      check("queue_head", 0, {24'd0, byte_in}, 32'h44);
      check("queue_left", 0, q.size(), 1);
      q.delete();

      // Zero-length start is ignored.
      start     = 1'b1;
      frame_len = 11'd0;
      idle_ticks(100, "zero_len");
      start = 1'b0;

      // Start held high: two back-to-back frames with the same two bytes.
      load_frame(2);
      q.push_back(fdata[0]);
      q.push_back(fdata[1]);
      run_frame(2, 1'b1, 0, 0, "b2b_first");
      run_frame(2, 1'b0, 0, 0, "b2b_second");
      idle_ticks(2, "b2b_idle");

      // Random frames with random idle spacing.
      repeat (4) begin
         idle_ticks(int'($urandom_range(0, 4)), "rand_idle");
         len = int'($urandom_range(1, 8));
         load_frame(len);
         run_frame(len, 1'b0, 0, 0, "rand_frame");
      end

      // Asynchronous reset in the middle of DATA.
      q.delete();
      load_frame(4);
      start     = 1'b1;
      frame_len = 11'd4;
      @(posedge clk_in);
      #1;
      start = 1'b0;
      repeat (34) tick(obs);
      @(posedge clk_in);
      #5;
      check("pre_reset_txen", 35, {31'd0, txen}, 32'd1);
      rst_in = 1'b0;
      #1;
      check("async_reset", 35, {26'd0, txen, txd, advance, done, busy}, 32'd0);
      tick(obs);
      tick(obs);
      rst_in = 1'b1;
      q.delete();
      load_frame(2);
      run_frame(2, 1'b0, 0, 0, "after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
